// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store controller driving a req/ack data bus with timeout abort
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  localparam int CNT_WIDTH = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        ErrorM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_shift;
  logic        req;
  logic        timeout_hit;
  assign req         = MemReadM | MemWriteM;
  assign timeout_hit = cnt == CNT_WIDTH'(TIMEOUT - 1);
  assign rdata_shift = bus_rdata >> {lane_q, 3'b000};
  assign ReadDataM   = rdata_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // StallM is gated by reset so an asserted reset releases the pipeline immediately
  always_comb begin
    state_nx = state == IDLE ? (req ? BUSY : IDLE)
             : state == BUSY ? ((bus_ack || timeout_hit) ? DONE : BUSY)
             : IDLE;
    StallM   = reset & (state == IDLE ? req : state == BUSY);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
      rdata_q   <= '0;
      cnt       <= '0;
      ErrorM    <= 1'b0;
    end else if (state == IDLE && req) begin
      bus_req   <= 1'b1;
      bus_we    <= MemWriteM;
      bus_addr  <= {ALUOutM[31:2], 2'b00};
      bus_wdata <= ByteM ? {4{WriteDataM[7:0]}} : WriteDataM;
      bus_be    <= ByteM ? 4'b0001 << ALUOutM[1:0] : 4'b1111;
      byte_q    <= ByteM;
      lane_q    <= ALUOutM[1:0];
      cnt       <= '0;
    end else if (state == BUSY) begin
      if (bus_ack) begin
        bus_req <= 1'b0;
        rdata_q <= byte_q ? {24'b0, rdata_shift[7:0]} : bus_rdata;
      end else if (timeout_hit) begin
        bus_req <= 1'b0;
        ErrorM  <= 1'b1;
        rdata_q <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit (TIMEOUT=4)
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, ByteM = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM, ErrorM, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .ErrorM(ErrorM), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  // Called just after a falling edge; returns during the DONE cycle with inputs still held.
  // ack_at is the BUSY cycle (1-based) on which bus_ack is high; 0 means never.
  task automatic run_access(input logic rd, input logic wr, input logic bt,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_at, input logic [31:0] rdata,
                            output int stalls, output int req_cycles,
                            output logic [31:0] a, output logic [31:0] wd,
                            output logic [3:0] be, output logic we);
    MemReadM = rd; MemWriteM = wr; ByteM = bt; ALUOutM = addr; WriteDataM = wdata;
    bus_rdata = rdata;
    stalls = 0; req_cycles = 0; a = 'x; wd = 'x; be = 'x; we = 1'bx;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (StallM) stalls++;
      if (bus_req) begin
        req_cycles++;
        if (req_cycles == 1) begin a = bus_addr; wd = bus_wdata; be = bus_be; we = bus_we; end
      end
      if (c > 0 && !StallM) break;
      bus_ack = ack_at != 0 && c == ack_at;
      @(negedge clk);
    end
    bus_ack = 1'b0;
  endtask
  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
  endtask
  task automatic test_reset();
    MemReadM = 1'b1;
    #1;
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", StallM); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus_req); end
    checks++; if ({bus_addr, bus_wdata, bus_be, bus_we} !== '0) begin failures++; $display("FAIL reset_bus got=%h/%h/%h/%b exp=0", bus_addr, bus_wdata, bus_be, bus_we); end
    checks++; if ({ReadDataM, ErrorM} !== '0) begin failures++; $display("FAIL reset_rd_err got=%h/%b exp=0", ReadDataM, ErrorM); end
    clear_inputs();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_word_load();
    int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
    run_access(1, 0, 0, 32'h0000_0104, 32'h0, 3, 32'hDEAD_BEEF, st, rq, a, wd, be, we);
    checks++; if (a !== 32'h104) begin failures++; $display("FAIL wl_addr got=%h exp=104", a); end
    checks++; if (be !== 4'hF) begin failures++; $display("FAIL wl_be got=%h exp=f", be); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL wl_we got=%b exp=0", we); end
    checks++; if (st !== 4) begin failures++; $display("FAIL wl_stall got=%0d exp=4", st); end
    checks++; if (ReadDataM !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wl_rdata got=%h exp=deadbeef", ReadDataM); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL wl_req_done got=%b exp=0", bus_req); end
    clear_inputs(); @(negedge clk);
  endtask
  task automatic test_byte_store();
    int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
    run_access(0, 1, 1, 32'h0000_0022, 32'h1234_56A5, 1, 32'h0, st, rq, a, wd, be, we);
    checks++; if (a !== 32'h20) begin failures++; $display("FAIL bs_addr got=%h exp=20", a); end
    checks++; if (be !== 4'b0100) begin failures++; $display("FAIL bs_be got=%b exp=0100", be); end
    checks++; if (wd !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bs_wdata got=%h exp=a5a5a5a5", wd); end
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL bs_we got=%b exp=1", we); end
    checks++; if (st !== 2) begin failures++; $display("FAIL bs_stall got=%0d exp=2", st); end
    clear_inputs(); @(negedge clk);
  endtask
  task automatic test_byte_load();
    int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
    run_access(1, 0, 1, 32'h0000_0003, 32'h0, 2, 32'h80FF_0000, st, rq, a, wd, be, we);
    checks++; if (be !== 4'b1000) begin failures++; $display("FAIL bl_be got=%b exp=1000", be); end
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL bl_addr got=%h exp=0", a); end
    checks++; if (ReadDataM !== 32'h0000_0080) begin failures++; $display("FAIL bl_rdata got=%h exp=00000080", ReadDataM); end
    checks++; if (st !== 3) begin failures++; $display("FAIL bl_stall got=%0d exp=3", st); end
    checks++; if (ErrorM !== 1'b0) begin failures++; $display("FAIL bl_err got=%b exp=0", ErrorM); end
    clear_inputs(); @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
    run_access(1, 0, 0, 32'h0000_0010, 32'h0, 1, 32'h1111_1111, st, rq, a, wd, be, we);
    checks++; if (StallM !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL b2b_done1 got=%b/%b exp=0/0", StallM, bus_req); end
    @(negedge clk);
    run_access(1, 0, 0, 32'h0000_0014, 32'h0, 2, 32'h2222_2222, st, rq, a, wd, be, we);
    checks++; if (st !== 3) begin failures++; $display("FAIL b2b_stall2 got=%0d exp=3", st); end
    checks++; if (a !== 32'h14 || ReadDataM !== 32'h2222_2222) begin failures++; $display("FAIL b2b_load2 got=%h/%h exp=14/22222222", a, ReadDataM); end
    @(negedge clk);
    run_access(1, 1, 0, 32'h0000_0030, 32'hCAFE_F00D, 1, 32'h0000_0077, st, rq, a, wd, be, we);
    checks++; if (we !== 1'b1 || wd !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_rw_store got=%b/%h exp=1/cafef00d", we, wd); end
    checks++; if (st !== 2) begin failures++; $display("FAIL b2b_stall3 got=%0d exp=2", st); end
    clear_inputs(); @(negedge clk);
  endtask
  task automatic test_timeout();
    int st, rq; logic [31:0] a, wd; logic [3:0] be; logic we;
    run_access(1, 0, 0, 32'h0000_0040, 32'h0, 0, 32'hFFFF_FFFF, st, rq, a, wd, be, we);
    checks++; if (rq !== 4) begin failures++; $display("FAIL to_req_cycles got=%0d exp=4", rq); end
    checks++; if (st !== 5) begin failures++; $display("FAIL to_stall got=%0d exp=5", st); end
    checks++; if (ErrorM !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", ErrorM); end
    checks++; if (ReadDataM !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", ReadDataM); end
    clear_inputs(); @(negedge clk);
    run_access(1, 0, 0, 32'h0000_0044, 32'h0, 1, 32'h0BAD_F00D, st, rq, a, wd, be, we);
    checks++; if (ReadDataM !== 32'h0BAD_F00D) begin failures++; $display("FAIL to_next_rdata got=%h exp=0badf00d", ReadDataM); end
    checks++; if (ErrorM !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", ErrorM); end
    clear_inputs(); @(negedge clk);
  endtask
  task automatic test_reset_mid_busy();
    MemReadM = 1'b1; ALUOutM = 32'h50; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rmb_req got=%b exp=0", bus_req); end
    checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL rmb_stall got=%b exp=0", StallM); end
    checks++; if (ErrorM !== 1'b0 || ReadDataM !== 32'h0) begin failures++; $display("FAIL rmb_err_rd got=%b/%h exp=0/0", ErrorM, ReadDataM); end
    clear_inputs();
    @(negedge clk); reset = 1'b1;
    bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0;
    #1;
    checks++; if (StallM !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL rmb_idle got=%b/%b exp=0/0", StallM, bus_req); end
    checks++; if (ReadDataM !== 32'h0) begin failures++; $display("FAIL rmb_ack_ignored got=%h exp=0", ReadDataM); end
  endtask
  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_back_to_back();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store controller sitting directly downstream of the pipelined datapath's M stage.
- Consumes the M-stage address (ALUOutM), store data (WriteDataM) and memory controls, then runs a req/ack transaction on a multi-cycle data bus.
- Returns ReadDataM to the datapath's M/W register and raises StallM to the hazard unit while an access is in flight.
- Supports word and byte (LDRB/STRB) accesses, and aborts with a sticky error after a bus timeout.

Parameters:
TIMEOUT, 16, max BUSY cycles waited for bus_ack before abort (>=1)
CNT_WIDTH, $clog2(TIMEOUT+1), width of the timeout counter (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
MemReadM  input  1  M-stage instruction is a load
MemWriteM  input  1  M-stage instruction is a store
ByteM  input  1  1 = byte access, 0 = word access
ALUOutM  input  32  effective address
WriteDataM  input  32  store data
ReadDataM  output  32  load result to the M/W pipeline register
StallM  output  1  stall request to the hazard unit (freezes F/D/E/M)
ErrorM  output  1  sticky bus-timeout flag
bus_req  output  1  bus request, held until ack or abort
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address ({ALUOutM[31:2],2'b00})
bus_wdata  output  32  write data
bus_be  output  4  byte enables
bus_rdata  input  32  read data, valid when bus_ack=1
bus_ack  input  1  transfer complete (single-cycle pulse)

Behaviour:
- Reset (reset=0, async): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata latch=0, timeout counter=0, ErrorM=0. StallM=0 while in reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If MemReadM|MemWriteM, StallM=1 combinationally in the same cycle.
  - At the next edge, bus_* outputs are registered from the M-stage inputs, bus_req=1, counter=0, state goes to BUSY.
  - Otherwise StallM=0 and the unit stays in IDLE.
- If MemReadM and MemWriteM are both 1, the access is treated as a store.
- Word access: bus_be=4'b1111, bus_wdata=WriteDataM. ALUOutM[1:0] is ignored; there is no misalignment trap.
- Byte access: bus_be=4'b0001<<ALUOutM[1:0], bus_wdata={4{WriteDataM[7:0]}}.
- BUSY:
  - StallM=1; bus_* outputs are held stable.
  - bus_ack=1: latch read data (word: bus_rdata; byte: selected lane, zero-extended), drop bus_req, go to DONE.
  - No ack and counter==TIMEOUT-1: drop bus_req, set ErrorM=1, latch 0 as read data, go to DONE.
  - Otherwise counter increments.
- DONE:
  - StallM=0; the pipeline advances at the end of this cycle; next state is IDLE.
  - The access is not re-issued in DONE even if MemReadM/MemWriteM remain 1.
- ReadDataM always drives the latched value; it is updated only on BUSY->DONE transitions.
- Stall length: StallM is high for 1+N cycles, where N = BUSY cycles up to and including the ack cycle (minimum 2 cycles). Maximum is 1+TIMEOUT.
- bus_ack sampled in IDLE or DONE is ignored.
- ErrorM is cleared only by reset. After a timeout the unit continues to accept accesses normally.
- Back-to-back accesses: DONE->IDLE, then a new request is detected in IDLE. This gives exactly one non-stalled cycle (DONE) between consecutive accesses.
- Reset asserted mid-BUSY: bus_req drops immediately (async) and the transaction is abandoned with no ReadDataM update.

Test Plan:
- Word load, ALUOutM=0x0000_0104, bus_ack after 3 BUSY cycles with bus_rdata=0xDEAD_BEEF -> bus_addr=0x104, bus_be=4'hF, bus_we=0; StallM high 4 cycles; ReadDataM=0xDEADBEEF in DONE.
- Byte store, ALUOutM=0x0000_0022, WriteDataM=0x1234_56A5, ack on first BUSY cycle -> bus_addr=0x20, bus_be=4'b0100, bus_wdata=0xA5A5A5A5, bus_we=1; StallM high 2 cycles.
- Byte load, ALUOutM=0x3, bus_rdata=0x80FF_0000 -> ReadDataM=0x0000_0080 (zero-extended lane 3).
- Timeout, TIMEOUT=4, load with bus_ack never asserted -> bus_req high exactly 4 cycles; ErrorM=1 and stays 1; ReadDataM=0; a following load acked normally completes with ErrorM still 1.
- Reset mid-BUSY (reset=0 on the 2nd BUSY cycle) -> bus_req, StallM and ErrorM fall without waiting for a clock; state IDLE; a later ack pulse is ignored.
- Two consecutive loads, then MemReadM=MemWriteM=1 -> exactly one StallM=0 cycle between transactions; the third access drives bus_we=1.
